// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the millisecond stopwatch.
// to_bcd2 turns an integer parameter into its two-digit BCD form.
package stopwatch_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_state_e;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX_5 = 4'd5;

    function automatic logic [2*DIGIT_W-1:0] to_bcd2(input int unsigned v);
        return {DIGIT_W'(v / 10), DIGIT_W'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: wraps at max_val and emits a carry on that wrap.
// digit_nxt exposes the value the digit will take at the next edge.
module bcd_digit_counter
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    input  logic [DIGIT_W-1:0] max_val,
    output logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] digit_nxt,
    output logic               carry
);

    logic at_max;

    assign at_max = (digit == max_val);
    assign carry  = inc & at_max & ~clr;

    always_comb begin
        digit_nxt = digit;
        if (clr)
            digit_nxt = '0;
        else if (inc)
            digit_nxt = at_max ? '0 : digit + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            digit <= '0;
        else
            digit <= digit_nxt;
    end

endmodule

// File: rtl/ms_stopwatch_counter.sv
// MM:SS.mmm BCD stopwatch driven by the millisecond tick, with run control,
// clear, and a lap mode that freezes the display while the count continues.
module ms_stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter bit TICK_IS_LEVEL = 1'b1,
    parameter int MAX_MIN       = 59
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ms_tick,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        lap,
    output logic [11:0] ms_bcd,
    output logic [7:0]  sec_bcd,
    output logic [7:0]  min_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    localparam logic [7:0] MAX_MIN_BCD = to_bcd2(MAX_MIN);

    run_state_e state, state_nxt;
    logic       tick_evt;
    logic       cnt_en;

    generate
        if (TICK_IS_LEVEL) begin : g_level
            logic tick_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    tick_q <= 1'b0;
                else
                    tick_q <= ms_tick;
            end
            assign tick_evt = ms_tick & ~tick_q;
        end else begin : g_pulse
            assign tick_evt = ms_tick;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= STOPPED;
        else
            state <= state_nxt;
    end

    // stop wins over a simultaneous start
    always_comb begin
        state_nxt = state;
        case (state)
            STOPPED: if (start && !stop) state_nxt = RUNNING;
            RUNNING: if (stop)           state_nxt = STOPPED;
            default:                     state_nxt = STOPPED;
        endcase
    end

    always_comb begin
        running = (state == RUNNING);
    end

    assign cnt_en = running & tick_evt & ~clear;

    logic [DIGIT_W-1:0] ms0, ms1, ms2, s0, s1, m0, m1;
    logic [DIGIT_W-1:0] ms0_n, ms1_n, ms2_n, s0_n, s1_n, m0_n, m1_n;
    logic c_ms0, c_ms1, c_ms2, c_s0, c_s1, c_m0, unused_c_m1;
    logic min_at_max, min_wrap, min_clr;

    // minutes wrap as a pair in one cycle instead of rippling per digit
    assign min_at_max = ({m1, m0} == MAX_MIN_BCD);
    assign min_wrap   = c_s1 & min_at_max;
    assign min_clr    = clear | min_wrap;

    bcd_digit_counter u_ms0 (.clk(clk), .rst_n(rst_n), .clr(clear), .inc(cnt_en),
        .max_val(DIGIT_MAX_9), .digit(ms0), .digit_nxt(ms0_n), .carry(c_ms0));
    bcd_digit_counter u_ms1 (.clk(clk), .rst_n(rst_n), .clr(clear), .inc(c_ms0),
        .max_val(DIGIT_MAX_9), .digit(ms1), .digit_nxt(ms1_n), .carry(c_ms1));
    bcd_digit_counter u_ms2 (.clk(clk), .rst_n(rst_n), .clr(clear), .inc(c_ms1),
        .max_val(DIGIT_MAX_9), .digit(ms2), .digit_nxt(ms2_n), .carry(c_ms2));
    bcd_digit_counter u_s0 (.clk(clk), .rst_n(rst_n), .clr(clear), .inc(c_ms2),
        .max_val(DIGIT_MAX_9), .digit(s0), .digit_nxt(s0_n), .carry(c_s0));
    bcd_digit_counter u_s1 (.clk(clk), .rst_n(rst_n), .clr(clear), .inc(c_s0),
        .max_val(DIGIT_MAX_5), .digit(s1), .digit_nxt(s1_n), .carry(c_s1));
    bcd_digit_counter u_m0 (.clk(clk), .rst_n(rst_n), .clr(min_clr), .inc(c_s1 & ~min_at_max),
        .max_val(DIGIT_MAX_9), .digit(m0), .digit_nxt(m0_n), .carry(c_m0));
    bcd_digit_counter u_m1 (.clk(clk), .rst_n(rst_n), .clr(min_clr), .inc(c_m0),
        .max_val(DIGIT_MAX_9), .digit(m1), .digit_nxt(m1_n), .carry(unused_c_m1));

    logic [27:0] live, live_nxt, disp, shown;

    assign live     = {m1, m0, s1, s0, ms2, ms1, ms0};
    assign live_nxt = {m1_n, m0_n, s1_n, s0_n, ms2_n, ms1_n, ms0_n};

    // lap capture takes the post-tick value so a same-cycle tick is included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp       <= '0;
            lap_active <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            disp       <= '0;
            lap_active <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (min_wrap)
                overflow <= 1'b1;
            if (lap) begin
                if (!lap_active)
                    disp <= live_nxt;
                lap_active <= ~lap_active;
            end
        end
    end

    assign shown   = lap_active ? disp : live;
    assign min_bcd = shown[27:20];
    assign sec_bcd = shown[19:12];
    assign ms_bcd  = shown[11:0];

endmodule

// File: tb/tb_ms_stopwatch_counter.sv
// Bench for ms_stopwatch_counter: a level-tick instance (MAX_MIN=59) plus a
// pulse-tick instance (MAX_MIN=0) that reaches its wrap point quickly.
module tb_ms_stopwatch_counter;

    localparam int LIMIT1 = 60 * 60000;
    localparam int LIMIT2 = 1 * 60000;

    logic        clk = 1'b0;
    logic        rst_n, ms_tick, start, stop, clear, lap;
    logic [11:0] ms_bcd;
    logic [7:0]  sec_bcd, min_bcd;
    logic        running, lap_active, overflow;

    logic        rst2_n, tick2, start2, clear2;
    logic [11:0] ms_bcd2;
    logic [7:0]  sec_bcd2, min_bcd2;
    logic        running2, lap_active2, overflow2;

    int checks = 0;
    int failures = 0;

    // reference model state: plain millisecond totals
    int m_cnt = 0, m_frz = 0;
    bit m_lap = 0, m_run = 0, m_ovf = 0, m_prev = 0;
    int n_cnt = 0;
    bit n_run = 0, n_ovf = 0;

    always #5 clk = ~clk;

    ms_stopwatch_counter #(.TICK_IS_LEVEL(1'b1), .MAX_MIN(59)) dut (
        .clk(clk), .rst_n(rst_n), .ms_tick(ms_tick), .start(start), .stop(stop),
        .clear(clear), .lap(lap), .ms_bcd(ms_bcd), .sec_bcd(sec_bcd), .min_bcd(min_bcd),
        .running(running), .lap_active(lap_active), .overflow(overflow));

    ms_stopwatch_counter #(.TICK_IS_LEVEL(1'b0), .MAX_MIN(0)) dut2 (
        .clk(clk), .rst_n(rst2_n), .ms_tick(tick2), .start(start2), .stop(1'b0),
        .clear(clear2), .lap(1'b0), .ms_bcd(ms_bcd2), .sec_bcd(sec_bcd2), .min_bcd(min_bcd2),
        .running(running2), .lap_active(lap_active2), .overflow(overflow2));

    wire [30:0] obs1 = {min_bcd, sec_bcd, ms_bcd, running, lap_active, overflow};
    wire [30:0] obs2 = {min_bcd2, sec_bcd2, ms_bcd2, running2, lap_active2, overflow2};

    function automatic logic [30:0] exp_vec(int cnt, int frz, bit lapa, bit run, bit ovf);
        int v, ms, s, m;
        v  = lapa ? frz : cnt;
        ms = v % 1000;
        s  = (v / 1000) % 60;
        m  = v / 60000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10), run, lapa, ovf};
    endfunction

    task automatic chk(input string tag, input logic [30:0] obs, input logic [30:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit t, input bit s, input bit p, input bit c, input bit l);
        bit evt;
        ms_tick = t; start = s; stop = p; clear = c; lap = l;
        @(posedge clk);
        evt = t & ~m_prev;
        m_prev = t;
        if (c) begin
            m_cnt = 0; m_frz = 0; m_lap = 0; m_ovf = 0;
        end else begin
            if (m_run && evt) begin
                m_cnt++;
                if (m_cnt == LIMIT1) begin m_cnt = 0; m_ovf = 1; end
            end
            if (l) begin
                if (!m_lap) m_frz = m_cnt;
                m_lap = !m_lap;
            end
        end
        if (p) m_run = 0; else if (s) m_run = 1;
        if (clear2) begin
            n_cnt = 0; n_ovf = 0;
        end else if (n_run && tick2) begin
            n_cnt++;
            if (n_cnt == LIMIT2) begin n_cnt = 0; n_ovf = 1; end
        end
        if (start2) n_run = 1;
        #1;
        chk("model_main", obs1, exp_vec(m_cnt, m_frz, m_lap, m_run, m_ovf));
        chk("model_pulse", obs2, exp_vec(n_cnt, 0, 1'b0, n_run, n_ovf));
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        int guard;
        rst_n = 0; rst2_n = 0;
        ms_tick = 0; start = 0; stop = 0; clear = 0; lap = 0;
        tick2 = 0; start2 = 0; clear2 = 0;
        #12;
        chk("reset", obs1, 31'h0);
        chk("reset_pulse", obs2, 31'h0);
        #2 rst_n = 1; rst2_n = 1;

        // pulse instance: start once, tick every cycle from here on
        tick2 = 1; start2 = 1;
        step(0, 1, 0, 0, 0);
        start2 = 0;
        tick_n(1000);
        chk("one_second", obs1, {8'h00, 8'h01, 12'h000, 1'b1, 1'b0, 1'b0});

        step(0, 1, 0, 1, 0);
        tick_n(999);
        step(1, 0, 1, 0, 0);
        chk("stop_with_tick", obs1, {8'h00, 8'h01, 12'h000, 1'b0, 1'b0, 1'b0});
        step(0, 0, 0, 0, 0);
        tick_n(5);
        chk("stopped_hold", obs1, {8'h00, 8'h01, 12'h000, 1'b0, 1'b0, 1'b0});

        step(0, 1, 0, 1, 0);
        tick_n(250);
        step(0, 0, 0, 0, 1);
        chk("lap_freeze", obs1, {8'h00, 8'h00, 12'h250, 1'b1, 1'b1, 1'b0});
        tick_n(100);
        chk("lap_frozen", obs1, {8'h00, 8'h00, 12'h250, 1'b1, 1'b1, 1'b0});
        step(0, 0, 0, 0, 1);
        chk("lap_release", obs1, {8'h00, 8'h00, 12'h350, 1'b1, 1'b0, 1'b0});

        step(0, 0, 1, 1, 0);
        step(0, 1, 1, 0, 0);
        chk("start_stop_same", obs1, {8'h00, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0});
        step(0, 1, 0, 0, 0);
        tick_n(9);
        step(1, 0, 0, 1, 0);
        chk("clear_with_tick", obs1, {8'h00, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0});
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("after_clear", obs1, {8'h00, 8'h00, 12'h001, 1'b1, 1'b0, 1'b0});

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 1), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0));

        step(0, 1, 0, 1, 0);
        for (int i = 0; i < 50; i++) step(1, 0, 0, 0, 0);
        chk("level_hold", obs1, {8'h00, 8'h00, 12'h001, 1'b1, 1'b0, 1'b0});
        step(0, 0, 0, 0, 0);

        step(0, 1, 0, 1, 0);
        tick_n(12345);
        chk("pre_async", obs1, {8'h00, 8'h12, 12'h345, 1'b1, 1'b0, 1'b0});
        #2 rst_n = 0;
        #1 chk("async_reset", obs1, 31'h0);
        m_cnt = 0; m_frz = 0; m_lap = 0; m_run = 0; m_ovf = 0; m_prev = 0;
        #2 rst_n = 1;

        guard = 0;
        while (n_cnt != LIMIT2 - 1 && guard < 70000) begin
            step(0, 0, 0, 0, 0);
            guard++;
        end
        chk("pulse_pre_wrap", obs2, {8'h00, 8'h59, 12'h999, 1'b1, 1'b0, 1'b0});
        step(0, 0, 0, 0, 0);
        chk("pulse_wrap", obs2, {8'h00, 8'h00, 12'h000, 1'b1, 1'b0, 1'b1});
        step(0, 0, 0, 0, 0);
        chk("ovf_sticky", obs2, {8'h00, 8'h00, 12'h001, 1'b1, 1'b0, 1'b1});
        clear2 = 1;
        step(0, 0, 0, 0, 0);
        clear2 = 0;
        chk("ovf_clear", obs2, {8'h00, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
